// File: rtl/sdram_pkg.sv
// sdram_pkg: shared request type, queue FSM states and default widths for the SDRAM front end
package sdram_pkg;
   localparam int ADDR_W = 13;
   localparam int DATA_W = 16;
   localparam int DEPTH  = 4;
   localparam int STAT_W = 16;
   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } req_t;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} queue_state_e;
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction
endpackage

// File: rtl/sdram_req_fifo.sv
// sdram_req_fifo: synchronous power-of-two FIFO with combinational head read
module sdram_req_fifo #(
   parameter int Width = 8,
   parameter int Depth = 4,
   localparam int PtrW = $clog2(Depth)
) (
   input  logic             i_sys_clk,
   input  logic             i_rst,
   input  logic             push,
   input  logic             pop,
   input  logic [Width-1:0] wdata,
   output logic [Width-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [PtrW:0]    level
);
   logic [Width-1:0] mem [Depth];
   logic [PtrW-1:0] wp, rp;
   logic wr, rd;
   assign full  = level == (PtrW+1)'(Depth);
   assign empty = level == '0;
   assign wr    = push && !full;
   assign rd    = pop && !empty;
   assign rdata = mem[rp];
   always_ff @(posedge i_sys_clk)
      if (wr) mem[wp] <= wdata;
   always_ff @(posedge i_sys_clk)
      if (i_rst) begin
         wp    <= '0;
         rp    <= '0;
         level <= '0;
      end else begin
         wp    <= wr ? wp + 1'b1 : wp;
         rp    <= rd ? rp + 1'b1 : rp;
         level <= level + (PtrW+1)'(wr) - (PtrW+1)'(rd);
      end
endmodule

// File: rtl/sdram_req_queue.sv
// sdram_req_queue: in-order command buffer issuing one-cycle rd/wr pulses to the SDRAM controller.
// Define SDRAM_REQ_QUEUE_STATS_EN to add saturating issued-write/read counters.
module sdram_req_queue
   import sdram_pkg::*;
#(
   parameter int AddrWidth = ADDR_W,
   parameter int DataWidth = DATA_W,
   parameter int Depth     = DEPTH
) (
   input  logic                   i_sys_clk,
   input  logic                   i_rst,
   input  logic                   i_req_valid,
   output logic                   o_req_ready,
   input  logic                   i_req_we,
   input  logic [AddrWidth-1:0]   i_req_addr,
   input  logic [DataWidth-1:0]   i_req_data,
   output logic                   o_rsp_valid,
   output logic [DataWidth-1:0]   o_rsp_data,
   output logic [$clog2(Depth):0] o_level,
`ifdef SDRAM_REQ_QUEUE_STATS_EN
   output logic [STAT_W-1:0]      o_wr_count,
   output logic [STAT_W-1:0]      o_rd_count,
`endif
   output logic                   o_wr_req,
   output logic [AddrWidth-1:0]   o_wr_addr,
   output logic [DataWidth-1:0]   o_wr_data,
   output logic                   o_rd_req,
   output logic [AddrWidth-1:0]   o_rd_addr,
   input  logic                   i_ctrl_busy,
   input  logic                   i_rd_valid,
   input  logic [DataWidth-1:0]   i_rd_data
);
   typedef struct packed {
      logic                 we;
      logic [AddrWidth-1:0] addr;
      logic [DataWidth-1:0] data;
   } entry_t;
   entry_t in_ent, head;
   queue_state_e state;
   logic full, empty, pop, rd_pend, rsp_hit;
   assign in_ent      = '{we: i_req_we, addr: i_req_addr, data: i_req_data};
   assign o_req_ready = !full;
   assign pop         = state == IDLE && !empty && !i_ctrl_busy;
   assign rsp_hit     = rd_pend && i_rd_valid && (state == WAIT_ACK || state == WAIT_DONE);
   sdram_req_fifo #(.Width($bits(entry_t)), .Depth(Depth)) u_fifo (
      .i_sys_clk(i_sys_clk),
      .i_rst    (i_rst),
      .push     (i_req_valid && o_req_ready),
      .pop      (pop),
      .wdata    (in_ent),
      .rdata    (head),
      .full     (full),
      .empty    (empty),
      .level    (o_level)
   );
   always_ff @(posedge i_sys_clk)
      if (i_rst) begin
         state       <= IDLE;
         rd_pend     <= 1'b0;
         o_wr_req    <= 1'b0;
         o_rd_req    <= 1'b0;
         o_wr_addr   <= '0;
         o_wr_data   <= '0;
         o_rd_addr   <= '0;
         o_rsp_valid <= 1'b0;
         o_rsp_data  <= '0;
      end else begin
         o_wr_req    <= 1'b0;
         o_rd_req    <= 1'b0;
         o_rsp_valid <= rsp_hit;
         o_rsp_data  <= rsp_hit ? i_rd_data : o_rsp_data;
         case (state)
            IDLE:
               if (pop) begin
                  state    <= ISSUE;
                  rd_pend  <= !head.we;
                  o_wr_req <= head.we;
                  o_rd_req <= !head.we;
                  if (head.we) begin
                     o_wr_addr <= head.addr;
                     o_wr_data <= head.data;
                  end else o_rd_addr <= head.addr;
               end
            ISSUE:    state <= WAIT_ACK;
            WAIT_ACK: state <= i_ctrl_busy ? WAIT_DONE : WAIT_ACK;
            default:
               if (!i_ctrl_busy) begin
                  state   <= IDLE;
                  rd_pend <= 1'b0;
               end
         endcase
      end
`ifdef SDRAM_REQ_QUEUE_STATS_EN
   always_ff @(posedge i_sys_clk)
      if (i_rst) begin
         o_wr_count <= '0;
         o_rd_count <= '0;
      end else begin
         o_wr_count <= (state == ISSUE && o_wr_req) ? sat_inc(o_wr_count) : o_wr_count;
         o_rd_count <= (state == ISSUE && o_rd_req) ? sat_inc(o_rd_count) : o_rd_count;
      end
`endif
endmodule
